// File: rtl/micro_run_ctrl.sv
// Run controller for a small microcontroller: loads two operands into data RAM,
// releases the micro until it reaches a done PC (or times out), then reads back a 16-bit result.
module micro_run_ctrl #(
    parameter logic [7:0]  OPA_ADDR       = 8'h00,
    parameter logic [7:0]  OPB_ADDR       = 8'h01,
    parameter logic [7:0]  RES_LO_ADDR    = 8'h02,
    parameter logic [7:0]  RES_HI_ADDR    = 8'h03,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        _iClk,
    input  logic        _iReset,
    input  logic        _iStart,
    input  logic [7:0]  _iOpA,
    input  logic [7:0]  _iOpB,
    input  logic [7:0]  _iDonePc,
    input  logic [7:0]  _iMicroInstAddr,
    input  logic [7:0]  _iMicroRamAddr,
    input  logic [7:0]  _iMicroRamWData,
    input  logic        _iMicroRamWrite,
    input  logic [7:0]  _iRamRData,
    output logic [7:0]  _oRamAddr,
    output logic [7:0]  _oRamWData,
    output logic        _oRamWrite,
    output logic        _oMicroReset,
    output logic        _oBusy,
    output logic        _oDone,
    output logic        _oTimeout,
    output logic [15:0] _oResult
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_A  = 3'd1,
        WR_B  = 3'd2,
        RUN   = 3'd3,
        RD_LO = 3'd4,
        RD_HI = 3'd5,
        DONE  = 3'd6
    } state_e;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  opA_q, opA_d;
    logic [7:0]  opB_q, opB_d;
    logic [7:0]  donePc_q, donePc_d;
    logic [15:0] count_q, count_d;
    logic [15:0] result_q, result_d;
    logic        timeout_q, timeout_d;
    logic        pcMatch;

    always_ff @(posedge _iClk) begin
        if (_iReset) begin
            state_q   <= IDLE;
            opA_q     <= 8'h00;
            opB_q     <= 8'h00;
            donePc_q  <= 8'h00;
            count_q   <= 16'h0000;
            result_q  <= 16'h0000;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            donePc_q  <= donePc_d;
            count_q   <= count_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    // The first two RUN cycles are masked so a stale PC left over from reset cannot end the run.
    assign pcMatch = (count_q >= 16'd2) && (_iMicroInstAddr == donePc_q);

    always_comb begin
        state_d      = state_q;
        opA_d        = opA_q;
        opB_d        = opB_q;
        donePc_d     = donePc_q;
        count_d      = count_q;
        result_d     = result_q;
        timeout_d    = timeout_q;
        _oRamAddr    = 8'h00;
        _oRamWData   = 8'h00;
        _oRamWrite   = 1'b0;
        _oMicroReset = 1'b1;
        _oDone       = 1'b0;

        case (state_q)
            IDLE: begin
                if (_iStart) begin
                    opA_d     = _iOpA;
                    opB_d     = _iOpB;
                    donePc_d  = _iDonePc;
                    result_d  = 16'h0000;
                    timeout_d = 1'b0;
                    state_d   = WR_A;
                end
            end
            WR_A: begin
                _oRamAddr  = OPA_ADDR;
                _oRamWData = opA_q;
                _oRamWrite = 1'b1;
                state_d    = WR_B;
            end
            WR_B: begin
                _oRamAddr  = OPB_ADDR;
                _oRamWData = opB_q;
                _oRamWrite = 1'b1;
                count_d    = 16'h0000;
                state_d    = RUN;
            end
            RUN: begin
                _oMicroReset = 1'b0;
                _oRamAddr    = _iMicroRamAddr;
                _oRamWData   = _iMicroRamWData;
                _oRamWrite   = _iMicroRamWrite;
                count_d      = count_q + 16'd1;
                // A match in the final allowed cycle still wins over the timeout.
                if (pcMatch) begin
                    state_d = RD_LO;
                end else if (count_q == TIMEOUT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            RD_LO: begin
                _oRamAddr      = RES_LO_ADDR;
                result_d[7:0]  = _iRamRData;
                state_d        = RD_HI;
            end
            RD_HI: begin
                _oRamAddr      = RES_HI_ADDR;
                result_d[15:8] = _iRamRData;
                state_d        = DONE;
            end
            DONE: begin
                _oDone  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign _oBusy    = (state_q != IDLE);
    assign _oTimeout = timeout_q;
    assign _oResult  = result_q;

endmodule

// File: tb/tb_micro_run_ctrl.sv
// Scoreboard bench for micro_run_ctrl: a scripted micro stub and a RAM model drive the DUT,
// expected completions are queued at each accepted start and checked when _oDone pulses.
module tb_micro_run_ctrl;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  opA, opB, donePc;
    logic [7:0]  microInstAddr, microRamAddr, microRamWData;
    logic        microRamWrite;
    logic [7:0]  ramRData;
    logic [7:0]  oRamAddr, oRamWData;
    logic        oRamWrite, oMicroReset, oBusy, oDone, oTimeout;
    logic [15:0] oResult;

    typedef struct {
        logic [15:0] result;
        logic        timeout;
        int          doneCycle;
    } exp_t;

    exp_t        expQ[$];
    int          vectors = 0;
    int          errors = 0;
    int          cycleCount = 0;
    int          microCycle = 0;
    int          stubMatchAt = -1;
    bit          stubEarly = 1'b0;
    logic [7:0]  stubPc = 8'h00;
    logic [7:0]  stubLo = 8'h00;
    logic [7:0]  stubHi = 8'h00;
    logic        leakSeen = 1'b0;
    logic [7:0]  ram [256];

    micro_run_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        ._iClk          (clk),
        ._iReset        (reset),
        ._iStart        (start),
        ._iOpA          (opA),
        ._iOpB          (opB),
        ._iDonePc       (donePc),
        ._iMicroInstAddr(microInstAddr),
        ._iMicroRamAddr (microRamAddr),
        ._iMicroRamWData(microRamWData),
        ._iMicroRamWrite(microRamWrite),
        ._iRamRData     (ramRData),
        ._oRamAddr      (oRamAddr),
        ._oRamWData     (oRamWData),
        ._oRamWrite     (oRamWrite),
        ._oMicroReset   (oMicroReset),
        ._oBusy         (oBusy),
        ._oDone         (oDone),
        ._oTimeout      (oTimeout),
        ._oResult       (oResult)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // RAM model with asynchronous read; address 0x10 is only ever written by a frozen micro.
    always @(posedge clk) begin
        if (oRamWrite) ram[oRamAddr] <= oRamWData;
        if (oRamWrite && oRamAddr == 8'h10) leakSeen <= 1'b1;
    end
    assign ramRData = ram[oRamAddr];

    // Micro stub: counts cycles since release, writes lo/hi at cycles 5/6, shows the done PC at stubMatchAt.
    always @(posedge clk) microCycle <= oMicroReset ? 0 : microCycle + 1;

    always_comb begin
        microInstAddr = 8'h00;
        microRamAddr  = 8'h55;
        microRamWData = 8'hA5;
        microRamWrite = 1'b0;
        if (oMicroReset) begin
            microRamAddr  = 8'h10;
            microRamWData = 8'hEE;
            microRamWrite = 1'b1;
        end else begin
            if (microCycle == stubMatchAt || (stubEarly && microCycle < 2)) microInstAddr = stubPc;
            if (microCycle == 5) begin
                microRamAddr  = 8'h02;
                microRamWData = stubLo;
                microRamWrite = 1'b1;
            end else if (microCycle == 6) begin
                microRamAddr  = 8'h03;
                microRamWData = stubHi;
                microRamWrite = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [7:0] pc,
                                 input int matchAt, input bit early, input logic [7:0] lo,
                                 input logic [7:0] hi, input logic [15:0] expRes, input bit expTo,
                                 input int lat, input bit expectDone, output int startCycle);
        exp_t e;
        stubPc      = pc;
        stubMatchAt = matchAt;
        stubEarly   = early;
        stubLo      = lo;
        stubHi      = hi;
        opA         = a;
        opB         = b;
        donePc      = pc;
        start       = 1'b1;
        startCycle  = cycleCount;
        if (expectDone) begin
            e.result    = expRes;
            e.timeout   = expTo;
            e.doneCycle = startCycle + lat;
            expQ.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic pulseStart(input logic [7:0] a, input logic [7:0] b, input logic [7:0] pc);
        opA    = a;
        opB    = b;
        donePc = pc;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (oBusy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_idle", {31'd0, oBusy}, 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (oDone) begin
            if (expQ.size() == 0) begin
                vectors++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected none", cycleCount);
            end else begin
                e = expQ.pop_front();
                checkOutput("done_cycle", cycleCount, e.doneCycle);
                checkOutput("result", {16'd0, oResult}, {16'd0, e.result});
                checkOutput("timeout", {31'd0, oTimeout}, {31'd0, e.timeout});
                checkOutput("done_micro_reset", {31'd0, oMicroReset}, 32'd1);
                checkOutput("done_busy", {31'd0, oBusy}, 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        reset  = 1'b1;
        start  = 1'b0;
        opA    = 8'h00;
        opB    = 8'h00;
        donePc = 8'h00;

        // Reset for two edges, with start held high on the second to check reset precedence.
        tick();
        start = 1'b1;
        tick();
        checkOutput("rst_micro_reset", {31'd0, oMicroReset}, 32'd1);
        checkOutput("rst_ram_write", {31'd0, oRamWrite}, 32'd0);
        checkOutput("rst_ram_addr", {24'd0, oRamAddr}, 32'd0);
        checkOutput("rst_ram_wdata", {24'd0, oRamWData}, 32'd0);
        checkOutput("rst_busy", {31'd0, oBusy}, 32'd0);
        checkOutput("rst_done", {31'd0, oDone}, 32'd0);
        checkOutput("rst_timeout", {31'd0, oTimeout}, 32'd0);
        checkOutput("rst_result", {16'd0, oResult}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        checkOutput("idle_after_reset", {31'd0, oBusy}, 32'd0);

        // Normal run: match at RUN cycle 20, done at start+26.
        tick();
        applyStimulus(8'd7, 8'd9, 8'h87, 20, 1'b0, 8'h3F, 8'h00, 16'h003F, 1'b0, 26, 1'b1, s);
        @(negedge clk);
        checkOutput("wr_a_addr", {24'd0, oRamAddr}, 32'h00);
        checkOutput("wr_a_data", {24'd0, oRamWData}, 32'd7);
        checkOutput("wr_a_write", {31'd0, oRamWrite}, 32'd1);
        checkOutput("wr_a_busy", {31'd0, oBusy}, 32'd1);
        tick();
        @(negedge clk);
        checkOutput("wr_b_addr", {24'd0, oRamAddr}, 32'h01);
        checkOutput("wr_b_data", {24'd0, oRamWData}, 32'd9);
        checkOutput("wr_b_write", {31'd0, oRamWrite}, 32'd1);
        tick();
        @(negedge clk);
        checkOutput("run_micro_reset", {31'd0, oMicroReset}, 32'd0);
        checkOutput("run_pass_addr", {24'd0, oRamAddr}, 32'h55);
        checkOutput("run_pass_data", {24'd0, oRamWData}, 32'hA5);
        checkOutput("run_pass_write", {31'd0, oRamWrite}, 32'd0);
        waitIdle(100);
        checkOutput("ram_opa", {24'd0, ram[0]}, 32'd7);
        checkOutput("ram_opb", {24'd0, ram[1]}, 32'd9);
        checkOutput("normal_result_held", {16'd0, oResult}, 32'h003F);
        checkOutput("normal_timeout", {31'd0, oTimeout}, 32'd0);

        // Timeout run: PC never matches, done at start+3+TIMEOUT.
        tick();
        applyStimulus(8'd3, 8'd4, 8'h99, -1, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b1, 3 + TIMEOUT, 1'b1, s);
        waitIdle(200);
        checkOutput("to_flag_held", {31'd0, oTimeout}, 32'd1);
        checkOutput("to_result_zero", {16'd0, oResult}, 32'd0);
        checkOutput("to_micro_reset", {31'd0, oMicroReset}, 32'd1);

        // Starts during RUN and during DONE are ignored; a start one cycle after DONE is taken.
        tick();
        applyStimulus(8'h11, 8'h22, 8'h77, 30, 1'b0, 8'hAB, 8'hCD, 16'hCDAB, 1'b0, 36, 1'b1, s);
        repeat (12) tick();
        pulseStart(8'hFF, 8'hFF, 8'h12);
        while (cycleCount < s + 36) tick();
        pulseStart(8'hEE, 8'hEE, 8'h13);
        checkOutput("after_done_result", {16'd0, oResult}, 32'hCDAB);
        checkOutput("after_done_busy", {31'd0, oBusy}, 32'd0);
        checkOutput("ignored_ram_opa", {24'd0, ram[0]}, 32'h11);
        checkOutput("ignored_ram_opb", {24'd0, ram[1]}, 32'h22);
        applyStimulus(8'd5, 8'd6, 8'h33, 10, 1'b0, 8'h5A, 8'h01, 16'h015A, 1'b0, 16, 1'b1, s);
        waitIdle(100);
        checkOutput("restart_ram_opa", {24'd0, ram[0]}, 32'd5);

        // Reset at RUN cycle 10 aborts the run; a following run behaves normally.
        tick();
        applyStimulus(8'd1, 8'd2, 8'h44, 40, 1'b0, 8'h00, 8'h00, 16'h0000, 1'b0, 0, 1'b0, s);
        repeat (12) tick();
        reset = 1'b1;
        tick();
        checkOutput("midrst_busy", {31'd0, oBusy}, 32'd0);
        checkOutput("midrst_micro_reset", {31'd0, oMicroReset}, 32'd1);
        checkOutput("midrst_ram_write", {31'd0, oRamWrite}, 32'd0);
        checkOutput("midrst_result", {16'd0, oResult}, 32'd0);
        reset = 1'b0;
        tick();
        applyStimulus(8'd7, 8'd9, 8'h87, 20, 1'b0, 8'h3F, 8'h00, 16'h003F, 1'b0, 26, 1'b1, s);
        waitIdle(100);

        // Match in the last allowed cycle wins over the timeout.
        tick();
        applyStimulus(8'hA0, 8'hB0, 8'h66, TIMEOUT - 1, 1'b0, 8'h12, 8'h34, 16'h3412, 1'b0, TIMEOUT + 5, 1'b1, s);
        waitIdle(200);
        checkOutput("tie_timeout", {31'd0, oTimeout}, 32'd0);

        // PC equal to done PC at counters 0 and 1 is ignored; real match at 25.
        tick();
        applyStimulus(8'hC0, 8'hD0, 8'h5B, 25, 1'b1, 8'h21, 8'h43, 16'h4321, 1'b0, 31, 1'b1, s);
        waitIdle(100);

        // Earliest honoured match at counter 2: stub has not written yet, RAM keeps 0x4321.
        tick();
        applyStimulus(8'hE0, 8'hF0, 8'h6C, 2, 1'b0, 8'h99, 8'h88, 16'h4321, 1'b0, 8, 1'b1, s);
        waitIdle(100);

        tick();
        tick();
        checkOutput("queue_empty", expQ.size(), 32'd0);
        checkOutput("no_micro_leak", {31'd0, leakSeen}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
